// File: rtl/ddr3_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_mem_arbiter_if
// Purpose  : Requester, response and memory-command signals of the arbiter.
// Revision : 1.0
// ============================================================================
interface ddr3_mem_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    logic              rq0_valid;
    logic              rq0_ready;
    logic              rq0_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic              rs0_valid;
    logic [DATA_W-1:0] rs0_data;

    logic              rq1_valid;
    logic              rq1_ready;
    logic              rq1_we;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;
    logic              rs1_valid;
    logic [DATA_W-1:0] rs1_data;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        output rq0_ready, rs0_valid, rs0_data,
        input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        output rq1_ready, rs1_valid, rs1_data,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // Requesters and memory side
    modport master (
        output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
        input  rq0_ready, rs0_valid, rs0_data,
        output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
        input  rq1_ready, rs1_valid, rs1_data,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ddr3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_mem_arbiter
// Purpose  : Two-port DDR3 command arbiter, fixed priority to port 0 with a
//            starvation guard, registered command stage, in-order read tags.
// Options  : DDR3_ARB_STATS_EN adds stat_grant0/stat_grant1/stat_stall.
// Revision : 1.0
// ============================================================================
module ddr3_mem_arbiter #(
    parameter int ADDR_W          = 27,
    parameter int DATA_W          = 128,
    parameter int MAX_OUTSTANDING = 8,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                             clk,
    input  logic                             sys_rst,
    ddr3_mem_arbiter_if.slave                bus,
    output logic [$clog2(MAX_OUTSTANDING):0] rd_pending,
    output logic                             resp_err
`ifdef DDR3_ARB_STATS_EN
    ,
    output logic [31:0]                      stat_grant0,
    output logic [31:0]                      stat_grant1,
    output logic [31:0]                      stat_stall
`endif
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_FIFO_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SC_W-1:0]  C_STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_cmd_we;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;

    logic                r_tag [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [SC_W-1:0]     r_starve;

    logic                r_rs0_valid;
    logic                r_rs1_valid;
    logic [DATA_W-1:0]   r_rs0_data;
    logic [DATA_W-1:0]   r_rs1_data;
    logic                r_resp_err;

    logic                w_full;
    logic                w_empty;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_push;
    logic                w_pop;
    logic                w_head;

    assign w_full  = (r_count == C_FIFO_FULL);
    assign w_empty = (r_count == '0);
    assign w_elig0 = bus.rq0_valid && (bus.rq0_we || !w_full);
    assign w_elig1 = bus.rq1_valid && (bus.rq1_we || !w_full);

    // The read slot is reserved at grant time, so a full FIFO can never be
    // overrun by a command that is already waiting in the issue register.
    assign w_push  = (w_grant0 && !bus.rq0_we) || (w_grant1 && !bus.rq1_we);
    assign w_pop   = bus.mem_rvalid && !w_empty;
    assign w_head  = r_tag[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        if (r_state == S_IDLE) begin
            if (!sys_rst) begin
                if (w_elig1 && (!w_elig0 || r_starve == C_STARVE_MAX)) begin
                    w_grant1 = 1'b1;
                end else if (w_elig0) begin
                    w_grant0 = 1'b1;
                end
            end
            if (w_grant0 || w_grant1) begin
                w_state_nxt = S_ISSUE;
            end
        end else begin
            if (bus.mem_ready) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_grant1) begin
            r_cmd_we    <= bus.rq1_we;
            r_cmd_addr  <= bus.rq1_addr;
            r_cmd_wdata <= bus.rq1_wdata;
        end else if (w_grant0) begin
            r_cmd_we    <= bus.rq0_we;
            r_cmd_addr  <= bus.rq0_addr;
            r_cmd_wdata <= bus.rq0_wdata;
        end
    end

    // Tag storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_grant1;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst || !bus.rq1_valid || w_grant1) begin
            r_starve <= '0;
        end else if (w_grant0 && r_starve != C_STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_rs0_valid <= 1'b0;
            r_rs1_valid <= 1'b0;
            r_rs0_data  <= '0;
            r_rs1_data  <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_rs0_valid <= w_pop && !w_head;
            r_rs1_valid <= w_pop && w_head;
            if (w_pop && !w_head) begin
                r_rs0_data <= bus.mem_rdata;
            end
            if (w_pop && w_head) begin
                r_rs1_data <= bus.mem_rdata;
            end
            if (bus.mem_rvalid && w_empty) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    assign bus.rq0_ready = w_grant0;
    assign bus.rq1_ready = w_grant1;
    assign bus.rs0_valid = r_rs0_valid;
    assign bus.rs1_valid = r_rs1_valid;
    assign bus.rs0_data  = r_rs0_data;
    assign bus.rs1_data  = r_rs1_data;
    assign bus.mem_valid = (r_state == S_ISSUE);
    assign bus.mem_we    = r_cmd_we;
    assign bus.mem_addr  = r_cmd_addr;
    assign bus.mem_wdata = r_cmd_wdata;
    assign rd_pending    = r_count;
    assign resp_err      = r_resp_err;

`ifdef DDR3_ARB_STATS_EN
    logic [31:0] r_stat_grant0;
    logic [31:0] r_stat_grant1;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_stat_grant0 <= '0;
            r_stat_grant1 <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_grant0) begin
                r_stat_grant0 <= r_stat_grant0 + 32'd1;
            end
            if (w_grant1) begin
                r_stat_grant1 <= r_stat_grant1 + 32'd1;
            end
            if (r_state == S_ISSUE && !bus.mem_ready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_grant0 = r_stat_grant0;
    assign stat_grant1 = r_stat_grant1;
    assign stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: doc/ddr3_mem_arbiter.md
Name: ddr3_mem_arbiter

Overview:
- Shares the single DDR3 memory port of the MicroBlaze DDR3 subsystem between two requesters.
  - Port 0: video/sprite line fetch, high priority.
  - Port 1: game-logic/CPU bridge.
- Fixed priority to port 0, with a starvation guard for port 1.
- Single registered command stage toward memory; in-order read-tag FIFO routes each read response back to its originating port.

Parameters:
ADDR_W, 27, byte address width of memory commands
DATA_W, 128, data width of memory commands and responses
MAX_OUTSTANDING, 8, maximum reads in flight (tag FIFO depth, power of 2)
STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits

Ports:
clk  in  1  system clock (memory UI clock domain)
sys_rst  in  1  synchronous, active-high reset
rq0_valid  in  1  port 0 request valid
rq0_ready  out  1  port 0 request accepted this cycle
rq0_we  in  1  port 0: 1 = write, 0 = read
rq0_addr  in  ADDR_W  port 0 address
rq0_wdata  in  DATA_W  port 0 write data
rs0_valid  out  1  port 0 read response valid (1-cycle pulse)
rs0_data  out  DATA_W  port 0 read data
rq1_valid, rq1_ready, rq1_we, rq1_addr, rq1_wdata, rs1_valid, rs1_data: same as port 0, for port 1
mem_valid  out  1  command valid to memory
mem_ready  in  1  memory accepts command
mem_we  out  1  command is write
mem_addr  out  ADDR_W  command address
mem_wdata  out  DATA_W  command write data
mem_rvalid  in  1  read data return valid (in issue order)
mem_rdata  in  DATA_W  read data
rd_pending  out  clog2(MAX_OUTSTANDING)+1  reads in flight
resp_err  out  1  sticky: response arrived with no read in flight

Behaviour:
- Clock and reset: one clock `clk`; reset `sys_rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; tag FIFO empty; starve counter 0; resp_err 0. Reset mid-transaction discards the held command and all in-flight tags. Late responses then set resp_err.
- FSM states: IDLE, ISSUE.
- IDLE:
  - Eligible port = rqN_valid, and either rqN_we=1 or tag FIFO not full.
  - Grant rule: port 1 if eligible and (port 0 not eligible, or starve_cnt == STARVE_LIMIT). Otherwise port 0 if eligible.
  - On grant: rqN_ready=1 combinationally in the same cycle; capture we/addr/wdata into the command register; go to ISSUE.
  - rqN_ready is never asserted outside IDLE.
- ISSUE:
  - mem_valid=1 with stable we/addr/wdata until mem_valid && mem_ready, then IDLE.
  - Acceptance timing: accept at cycle N puts mem_valid at N+1. Peak throughput is one command per 2 cycles.
- Tag FIFO:
  - Pushes the port id at the IDLE grant of a read. Reserving the slot at grant closes the full race.
  - Pops on mem_rvalid. Push and pop in the same cycle leave the count unchanged and are legal when the FIFO is full.
  - rd_pending = FIFO count.
- Read responses:
  - rsN_valid/rsN_data registered: mem_rvalid at cycle M drives rsN_valid at M+1 to the port given by the FIFO head.
  - mem_rvalid with the FIFO empty: data dropped, no rs pulse, resp_err set until reset.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each port-0 grant while rq1_valid=1.
  - Clears on a port-1 grant or whenever rq1_valid=0.
- Writes never wait on the FIFO. Reads to a full FIFO are not eligible; the other port may still be granted.
- Widths: addresses and data pass through unmodified. No byte masks or ordering between ports beyond issue order.

Optional Feature:
- Macro: DDR3_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_grant0 [31:0]: counts port-0 grants.
  - stat_grant1 [31:0]: counts port-1 grants.
  - stat_stall [31:0]: counts ISSUE cycles with mem_ready=0.
  - All three wrap at 2^32 and clear on sys_rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port-0 read, addr 0x100, with mem_ready=1 and mem_rvalid two cycles after issue, rdata 0xA5 -> rq0_ready at N, mem_valid at N+1, rs0_valid with 0xA5 one cycle after mem_rvalid; rs1_valid stays 0.
- Both ports hold valid reads, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1; responses routed correctly in issue order.
- Port 1 issues 8 reads with no responses -> rd_pending=8; a 9th port-1 read is not accepted; a port-0 write is still accepted; one mem_rvalid frees a slot and the read is then accepted.
- Hold mem_ready=0 for 5 cycles in ISSUE -> mem_valid/addr/wdata stable, rq0_ready=rq1_ready=0, then one handshake; stat_stall=5 with DDR3_ARB_STATS_EN.
- mem_rvalid with rd_pending=0 -> no rs pulse, resp_err=1 and held until sys_rst.
- Assert sys_rst during ISSUE with 3 reads pending -> next cycle mem_valid=0, rd_pending=0, state IDLE; a subsequent late mem_rvalid sets resp_err.
